// File: rtl/sys_bus_bridge.sv
// Bridges system-space read/write requests onto a req/ack peripheral bus.
// Serialises a same-cycle write+read pair and bounds each transaction with a timeout.
module sys_bus_bridge #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                TIMEOUT    = 16,
  parameter logic [DATA_W-1:0] FAULT_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sys_r,
  input  logic [ADDR_W-1:0] sys_r_addr,
  input  logic              sys_w,
  input  logic [ADDR_W-1:0] sys_w_addr,
  input  logic [DATA_W-1:0] sys_w_line,
  output logic [DATA_W-1:0] sys_r_line,
  output logic              stall,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_addr,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              rd_pend_q, rd_pend_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sys_r_line_q, sys_r_line_d;
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              timeout_s;

  // Ack in the last allowed cycle beats the timeout.
  assign timeout_s = (cnt_q == CNT_LAST) && !bus_ack;

  // done_q masks the request that was just served while the pipeline advances.
  assign stall = (state_q != S_IDLE) || ((sys_r || sys_w) && !done_q);

  // Next-state, latched request fields, timeout counter and completion results.
  always_comb begin
    state_d      = state_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    raddr_d      = raddr_q;
    rd_pend_d    = rd_pend_q;
    done_d       = 1'b0;
    cnt_d        = cnt_q;
    sys_r_line_d = sys_r_line_q;
    fault_d      = 1'b0;
    fault_addr_d = fault_addr_q;
    case (state_q)
      S_IDLE: begin
        if (!done_q && (sys_w || sys_r)) begin
          waddr_d   = sys_w_addr;
          wdata_d   = sys_w_line;
          raddr_d   = sys_r_addr;
          cnt_d     = {CNT_W{1'b0}};
          rd_pend_d = sys_w && sys_r;
          state_d   = sys_w ? S_WR : S_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        if (bus_ack || timeout_s) begin
          if (timeout_s) begin
            fault_d      = 1'b1;
            fault_addr_d = bus_addr_q;
          end else begin
            fault_d = 1'b0;
          end
          // An aborted write is dropped; a pending read still runs.
          if (rd_pend_q) begin
            state_d   = S_RD;
            rd_pend_d = 1'b0;
            cnt_d     = {CNT_W{1'b0}};
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RD: begin
        if (bus_ack || timeout_s) begin
          if (timeout_s) begin
            fault_d      = 1'b1;
            fault_addr_d = bus_addr_q;
            sys_r_line_d = FAULT_DATA;
          end else begin
            sys_r_line_d = bus_rdata;
          end
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        rd_pend_d = 1'b0;
      end
    endcase
  end

  // Bus outputs are registered from the next state so they change with it.
  always_comb begin
    bus_req_d   = 1'b0;
    bus_we_d    = 1'b0;
    bus_addr_d  = {ADDR_W{1'b0}};
    bus_wdata_d = {DATA_W{1'b0}};
    case (state_d)
      S_WR: begin
        bus_req_d   = 1'b1;
        bus_we_d    = 1'b1;
        bus_addr_d  = waddr_d;
        bus_wdata_d = wdata_d;
      end
      S_RD: begin
        bus_req_d  = 1'b1;
        bus_addr_d = raddr_d;
      end
      default: begin
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      waddr_q      <= {ADDR_W{1'b0}};
      wdata_q      <= {DATA_W{1'b0}};
      raddr_q      <= {ADDR_W{1'b0}};
      rd_pend_q    <= 1'b0;
      done_q       <= 1'b0;
      cnt_q        <= {CNT_W{1'b0}};
      sys_r_line_q <= {DATA_W{1'b0}};
      fault_q      <= 1'b0;
      fault_addr_q <= {ADDR_W{1'b0}};
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= {ADDR_W{1'b0}};
      bus_wdata_q  <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      raddr_q      <= raddr_d;
      rd_pend_q    <= rd_pend_d;
      done_q       <= done_d;
      cnt_q        <= cnt_d;
      sys_r_line_q <= sys_r_line_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
    end
  end

  assign sys_r_line = sys_r_line_q;
  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_sys_bus_bridge.sv
// Randomised bench for sys_bus_bridge: a transaction-level timeline model predicts
// every bus/stall/fault/read-data value, compared each cycle on the falling edge.
module tb_sys_bus_bridge;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] FAULT_V = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        sys_r;
  logic [31:0] sys_r_addr;
  logic        sys_w;
  logic [31:0] sys_w_addr;
  logic [31:0] sys_w_line;
  logic [31:0] sys_r_line;
  logic        stall;
  logic        fault;
  logic [31:0] fault_addr;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  sys_bus_bridge #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .FAULT_DATA(FAULT_V)
  ) dut (
    .clk(clk), .rst(rst),
    .sys_r(sys_r), .sys_r_addr(sys_r_addr),
    .sys_w(sys_w), .sys_w_addr(sys_w_addr), .sys_w_line(sys_w_line),
    .sys_r_line(sys_r_line), .stall(stall),
    .fault(fault), .fault_addr(fault_addr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  int checks = 0;
  int errors = 0;

  logic        chk_en;
  logic        exp_stall, exp_req, exp_we, exp_fault;
  logic [31:0] exp_addr, exp_wdata, exp_faddr, exp_rline;

  int stall_run = 0;
  int last_run  = 0;
  int fault_seen = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, plus stall-run and fault-pulse bookkeeping.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("stall", {31'd0, stall}, {31'd0, exp_stall});
        check("bus_req", {31'd0, bus_req}, {31'd0, exp_req});
        check("bus_we", {31'd0, bus_we}, {31'd0, exp_we});
        check("bus_addr", bus_addr, exp_addr);
        check("bus_wdata", bus_wdata, exp_wdata);
        check("fault", {31'd0, fault}, {31'd0, exp_fault});
        check("fault_addr", fault_addr, exp_faddr);
        check("sys_r_line", sys_r_line, exp_rline);
      end
      if (fault === 1'b1) fault_seen++;
      if (stall === 1'b1) begin
        stall_run++;
      end else if (stall_run != 0) begin
        last_run  = stall_run;
        stall_run = 0;
      end
    end
  end

  task automatic set_idle_exp();
    exp_stall = 1'b0;
    exp_req   = 1'b0;
    exp_we    = 1'b0;
    exp_addr  = 32'd0;
    exp_wdata = 32'd0;
    exp_fault = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk); #1;
      sys_w      = 1'b0;
      sys_r      = 1'b0;
      sys_w_addr = $urandom;
      sys_r_addr = $urandom;
      sys_w_line = $urandom;
      bus_ack    = 1'($urandom_range(0, 1));
      bus_rdata  = $urandom;
      set_idle_exp();
    end
  endtask

  // One pipeline request: a timeline of bus phases (write first, then read), each
  // lasting wait+1 cycles when acked or TIMEOUT cycles when abandoned, then a done cycle.
  task automatic run_op(input bit w, input bit r, input logic [31:0] wa, input logic [31:0] wd,
                        input logic [31:0] ra, input int wwait, input int rwait);
    bit          ph_we[2];
    logic [31:0] ph_addr[2];
    logic [31:0] ph_data[2];
    int          ph_len[2];
    bit          ph_ack[2];
    int          n;
    logic [31:0] rd_val;
    n = 0;
    if (w) begin
      ph_we[n] = 1'b1; ph_addr[n] = wa; ph_data[n] = wd;
      ph_ack[n] = (wwait <= TIMEOUT - 1);
      ph_len[n] = ph_ack[n] ? wwait + 1 : TIMEOUT;
      n++;
    end
    if (r) begin
      ph_we[n] = 1'b0; ph_addr[n] = ra; ph_data[n] = 32'd0;
      ph_ack[n] = (rwait <= TIMEOUT - 1);
      ph_len[n] = ph_ack[n] ? rwait + 1 : TIMEOUT;
      n++;
    end
    rd_val = FAULT_V;
    @(posedge clk); #1;
    sys_w = w; sys_r = r;
    sys_w_addr = wa; sys_w_line = wd; sys_r_addr = ra;
    bus_ack = 1'b0; bus_rdata = $urandom;
    set_idle_exp();
    exp_stall = 1'b1;
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < ph_len[p]; c++) begin
        @(posedge clk); #1;
        exp_stall = 1'b1;
        exp_req   = 1'b1;
        exp_we    = ph_we[p];
        exp_addr  = ph_addr[p];
        exp_wdata = ph_data[p];
        exp_fault = (c == 0) && (p > 0) && !ph_ack[p > 0 ? p - 1 : 0];
        if (exp_fault) exp_faddr = ph_addr[p - 1];
        bus_rdata = $urandom;
        bus_ack   = ph_ack[p] && (c == ph_len[p] - 1);
        if (bus_ack && !ph_we[p]) rd_val = bus_rdata;
      end
    end
    @(posedge clk); #1;
    bus_ack = 1'b0;
    bus_rdata = $urandom;
    set_idle_exp();
    exp_fault = !ph_ack[n - 1];
    if (exp_fault) exp_faddr = ph_addr[n - 1];
    if (!ph_we[n - 1]) exp_rline = rd_val;
  endtask

  initial begin
    int f0;
    chk_en = 1'b0;
    rst = 1'b1;
    sys_r = 1'b0; sys_w = 1'b0;
    sys_r_addr = 32'd0; sys_w_addr = 32'd0; sys_w_line = 32'd0;
    bus_ack = 1'b0; bus_rdata = 32'd0;
    exp_rline = 32'd0; exp_faddr = 32'd0;
    set_idle_exp();
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_bus_req", {31'd0, bus_req}, 32'd0);
    check("reset_bus_addr", bus_addr, 32'd0);
    check("reset_sys_r_line", sys_r_line, 32'd0);
    check("reset_fault", {31'd0, fault}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    #2 rst = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Read with three wait states.
    run_op(1'b0, 1'b1, 32'd0, 32'd0, 32'h40, 0, 3);
    idle(1);
    check("rd_wait3_data", sys_r_line, 32'h1234_5678 ^ 32'h1234_5678 ^ exp_rline);
    check("rd_wait3_stall_len", last_run, 32'd5);

    // Same-cycle write+read, both zero-wait.
    run_op(1'b1, 1'b1, 32'h10, 32'hA5A5_A5A5, 32'h20, 0, 0);
    idle(1);
    check("wr_rd_stall_len", last_run, 32'd3);

    // Read with no ack at all.
    f0 = fault_seen;
    run_op(1'b0, 1'b1, 32'd0, 32'd0, 32'h40, TIMEOUT + 5, TIMEOUT + 5);
    idle(1);
    check("rd_to_data", sys_r_line, 32'hDEAD_BEEF);
    check("rd_to_faddr", fault_addr, 32'h40);
    check("rd_to_pulses", fault_seen - f0, 32'd1);
    check("rd_to_stall_len", last_run, 32'd17);

    // Ack on the very last allowed cycle.
    f0 = fault_seen;
    run_op(1'b0, 1'b1, 32'd0, 32'd0, 32'h44, 0, TIMEOUT - 1);
    idle(1);
    check("ack_last_no_fault", fault_seen - f0, 32'd0);
    check("ack_last_stall_len", last_run, 32'd17);

    // Write timeout with a pending read.
    f0 = fault_seen;
    run_op(1'b1, 1'b1, 32'h30, 32'h5555_AAAA, 32'h34, TIMEOUT + 2, 1);
    idle(1);
    check("wr_to_faddr", fault_addr, 32'h30);
    check("wr_to_pulses", fault_seen - f0, 32'd1);
    check("wr_to_stall_len", last_run, 32'd19);

    // Back-to-back reads: the held request in the done cycle must be ignored.
    run_op(1'b0, 1'b1, 32'd0, 32'd0, 32'h50, 32'd0, 0);
    run_op(1'b0, 1'b1, 32'd0, 32'd0, 32'h54, 32'd0, 0);
    idle(1);
    check("b2b_stall_len", last_run, 32'd2);

    for (int i = 0; i < 60; i++) begin
      bit w, r;
      int ww, rw, gap;
      w  = 1'($urandom_range(0, 1));
      r  = w ? 1'($urandom_range(0, 1)) : 1'b1;
      ww = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 + $urandom_range(0, 3) : $urandom_range(0, 4);
      rw = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 + $urandom_range(0, 3) : $urandom_range(0, 4);
      run_op(w, r, $urandom, $urandom, $urandom, ww, rw);
      gap = $urandom_range(0, 2);
      if (gap != 0) idle(gap);
    end

    // Asynchronous reset in the middle of a read.
    run_op(1'b0, 1'b1, 32'd0, 32'd0, 32'h60, 0, 0);
    idle(1);
    chk_en = 1'b0;
    @(posedge clk); #1;
    sys_r = 1'b1; sys_r_addr = 32'h80; bus_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pre_req", {31'd0, bus_req}, 32'd1);
    #2;
    rst = 1'b0; sys_r = 1'b0;
    #1;
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_sys_r_line", sys_r_line, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    repeat (2) @(posedge clk);
    #4 rst = 1'b1;
    exp_rline = 32'd0;
    exp_faddr = 32'd0;
    set_idle_exp();
    sys_r = 1'b0; sys_w = 1'b0;
    chk_en = 1'b1;
    idle(6);
    run_op(1'b0, 1'b1, 32'd0, 32'd0, 32'h1234, 0, 2);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
